// File: rtl/mem_if_pkg.sv
// Shared definitions for the L1 <-> main-memory bus: line geometry,
// requester state encoding and the assembled cache-line type.
package mem_if_pkg;

    localparam int LINE_WORDS = 8;
    localparam int WORD_W     = 32;
    localparam int BEAT_IDX_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        LD_ADDR,
        LD_DATA,
        ST_ADDR,
        ST_DATA,
        RESP
    } req_state_t;

    typedef logic [LINE_WORDS-1:0][WORD_W-1:0] line_t;

endpackage

// File: rtl/line_fill_buffer.sv
// Line assembly buffer: one register per word, written by beat index, plus a
// received mask. `full` means every word has been written since the last clear.
module line_fill_buffer
    import mem_if_pkg::*;
#(
    parameter int WORDS = LINE_WORDS,
    parameter int IDX_W = BEAT_IDX_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          wr_en,
    input  logic [IDX_W-1:0]              wr_idx,
    input  logic [WORD_W-1:0]             wr_data,
    output logic [WORDS-1:0][WORD_W-1:0]  line,
    output logic                          full
);

    logic [WORDS-1:0] mask;

    // Word storage and received mask. Clear only drops the mask: every word
    // is rewritten before full can assert again, so stale data never escapes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line <= '0;
            mask <= '0;
        end else if (clear) begin
            mask <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < WORDS; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    line[i] <= wr_data;
                    mask[i] <= 1'b1;
                end
            end
        end
    end

    assign full = &mask;

endmodule

// File: rtl/l1_mem_requester.sv
// Cache-side initiator for the L1 <-> main-memory bus. Issues one load
// (line fill) or store (write-through) at a time, assembles the returned
// line from indexed beats and reports completion to the cache.
// Optional feature macro: MEM_TIMEOUT_EN (watchdog, drives mem_error).
module l1_mem_requester #(
    parameter int LINE_WORDS     = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   req_valid,
    output logic                                   req_ready,
    input  logic                                   req_we,
    input  logic [31:0]                            req_addr,
    input  logic [31:0]                            req_wdata,
    output logic [31:0]                            L1Bus,
    output logic                                   valid,
    output logic                                   loadEnable,
    output logic                                   storeEnable,
    input  logic                                   memoryAddressReceive,
    input  logic                                   memoryBusValid,
    input  logic [31:0]                            memoryBus,
    input  logic [3:0]                             memoryBusCount,
    input  logic                                   cacheStoreComplete,
    output logic                                   fill_valid,
    output logic [31:0]                            fill_addr,
    output logic [LINE_WORDS*mem_if_pkg::WORD_W-1:0] fill_line,
    output logic                                   store_done,
    output logic                                   mem_error
);
    import mem_if_pkg::*;

    localparam int IDX_W = $clog2(LINE_WORDS);

    if (TIMEOUT_CYCLES < 2) begin : g_cfg_check
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    req_state_t state, nxt;

    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] line_base;
    logic [LINE_WORDS-1:0][WORD_W-1:0] buf_line;
    logic [LINE_WORDS-1:0][WORD_W-1:0] fill_line_q;
    logic [31:0] fill_addr_q;
    logic        buf_clear;
    logic        buf_wr;
    logic        buf_full;
    logic        beat_in_range;
    logic        active;
    logic        timeout_hit;

    assign line_base     = addr_q & ~32'(LINE_WORDS - 1);
    assign beat_in_range = {28'd0, memoryBusCount} < 32'(LINE_WORDS);
    assign active        = (state == LD_ADDR) || (state == LD_DATA) ||
                           (state == ST_ADDR) || (state == ST_DATA);

    line_fill_buffer #(
        .WORDS (LINE_WORDS),
        .IDX_W (IDX_W)
    ) u_lfb (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (buf_clear),
        .wr_en   (buf_wr),
        .wr_idx  (memoryBusCount[IDX_W-1:0]),
        .wr_data (memoryBus),
        .line    (buf_line),
        .full    (buf_full)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // Next-state and buffer control; stray bus inputs only matter in the
    // state that owns them. Completion uses the registered full flag so no
    // memory input reaches an output in the same cycle.
    always_comb begin
        nxt       = state;
        buf_clear = 1'b0;
        buf_wr    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    buf_clear = 1'b1;
                    nxt       = req_we ? ST_ADDR : LD_ADDR;
                end
            end
            LD_ADDR: if (memoryAddressReceive) nxt = LD_DATA;
            LD_DATA: begin
                buf_wr = memoryBusValid && beat_in_range;
                if (buf_full) nxt = RESP;
            end
            ST_ADDR: if (memoryAddressReceive) nxt = ST_DATA;
            ST_DATA: if (cacheStoreComplete)   nxt = RESP;
            RESP:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (timeout_hit) nxt = IDLE;
    end

    // Request capture on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state == IDLE && req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Completed line is copied out so it holds while the next fill assembles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_line_q <= '0;
            fill_addr_q <= '0;
        end else if (state == LD_DATA && buf_full && !timeout_hit) begin
            fill_line_q <= buf_line;
            fill_addr_q <= line_base;
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;
    logic            progress;
    logic            mem_error_q;

    assign progress =
        ((state == LD_ADDR || state == ST_ADDR) && memoryAddressReceive) ||
        buf_wr || (state == LD_DATA && buf_full) ||
        (state == ST_DATA && cacheStoreComplete);

    assign timeout_hit = active && !progress &&
                         (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts stalled cycles in any bus phase, reloads on progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 to_cnt <= '0;
        else if (!active || progress || timeout_hit) to_cnt <= '0;
        else                        to_cnt <= to_cnt + 1'b1;
    end

    // Error pulse lands in the cycle the FSM is back in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mem_error_q <= 1'b0;
        else        mem_error_q <= timeout_hit;
    end

    assign mem_error = mem_error_q;
`else
    assign timeout_hit = 1'b0;
    assign mem_error   = 1'b0;
`endif

    // Bus outputs decode from state and latched request only
    assign req_ready   = (state == IDLE);
    assign valid       = active;
    assign loadEnable  = (state == LD_ADDR) || (state == LD_DATA);
    assign storeEnable = (state == ST_ADDR) || (state == ST_DATA);
    assign L1Bus       = (state == LD_ADDR) ? line_base :
                         (state == ST_ADDR) ? addr_q    :
                         (state == ST_DATA) ? wdata_q   : 32'd0;
    assign fill_valid  = (state == RESP) && !we_q;
    assign store_done  = (state == RESP) &&  we_q;
    assign fill_line   = fill_line_q;
    assign fill_addr   = fill_addr_q;

endmodule
